// File: rtl/dec_count_pkg.sv
// Shared types for the decrement-count bank: per-channel state and index-width helper.
// State is held at the widest supported count width; narrower banks zero-extend into it.
package dec_count_pkg;

   localparam int MAX_WIDTH = 16;

   typedef struct packed {
      logic [MAX_WIDTH-1:0] count;
      logic [MAX_WIDTH-1:0] reload;
      logic                 auto_en;
   } chan_state_t;

   function automatic int chan_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dec_count_chan.sv
// One loadable down-counter channel with optional auto-reload and registered expire pulse.
// Latency: count/nonzero update on the edge; expire is the cycle after a terminal decrement.
module dec_count_chan
   import dec_count_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_load_auto,
   output logic [WIDTH-1:0] o_count,
   output logic             o_nonzero,
   output logic             o_expire
);

   chan_state_t          r_state;
   chan_state_t          w_state_nxt;
   logic                 r_expire;
   logic                 w_expire_nxt;
   logic                 w_nonzero;
   logic                 w_terminal;
   logic [MAX_WIDTH-1:0] w_load_ext;

   assign w_load_ext = MAX_WIDTH'(i_load_value);
   assign w_nonzero  = (r_state.count != '0);
   assign w_terminal = (r_state.count == MAX_WIDTH'(1));

   // Priority: enable low > load > decrement > hold. A load always masks expiry.
   always_comb begin
      w_state_nxt  = r_state;
      w_expire_nxt = 1'b0;
      if (!i_enable) begin
         w_state_nxt = '0;
      end else if (i_load) begin
         w_state_nxt.count   = w_load_ext;
         w_state_nxt.reload  = w_load_ext;
         w_state_nxt.auto_en = i_load_auto;
      end else if (i_tick && w_nonzero) begin
         if (w_terminal) begin
            w_expire_nxt      = 1'b1;
            w_state_nxt.count = (r_state.auto_en && (r_state.reload != '0)) ? r_state.reload : '0;
         end else begin
            w_state_nxt.count = r_state.count - MAX_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= '0;
         r_expire <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_expire <= w_expire_nxt;
      end
   end

   assign o_count   = r_state.count[WIDTH-1:0];
   assign o_nonzero = w_nonzero;
   assign o_expire  = r_expire;

endmodule

// File: rtl/dec_count_bank.sv
// Indexed bank of NCHAN independent down-counters sharing one tick strobe.
// rd_count is registered (1 cycle); nonzero is combinational from state; no backpressure.
module dec_count_bank
   import dec_count_pkg::*;
#(
   parameter  int NCHAN = 8,
   parameter  int WIDTH = 4,
   localparam int CW    = chan_idx_width(NCHAN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             tick,
   input  logic             load_valid,
   input  logic [CW-1:0]    load_chan,
   input  logic [WIDTH-1:0] load_value,
   input  logic             load_auto,
   input  logic [CW-1:0]    rd_chan,
   output logic [WIDTH-1:0] rd_count,
   output logic [NCHAN-1:0] nonzero,
   output logic [NCHAN-1:0] expire
);

   logic [NCHAN-1:0] w_load_oh;
   logic [WIDTH-1:0] w_count [NCHAN];
   logic [WIDTH-1:0] w_rd_mux;
   logic [WIDTH-1:0] r_rd_count;

   // Out-of-range indices match no channel, so they load nothing and read back zero.
   always_comb begin
      w_load_oh = '0;
      for (int i = 0; i < NCHAN; i++) begin
         w_load_oh[i] = load_valid && (load_chan == CW'(i));
      end
   end

   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (rd_chan == CW'(i)) begin
            w_rd_mux = w_count[i];
         end
      end
   end

   for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      dec_count_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .i_clk        (clk),
         .i_reset      (reset),
         .i_enable     (enable),
         .i_tick       (tick),
         .i_load       (w_load_oh[g]),
         .i_load_value (load_value),
         .i_load_auto  (load_auto),
         .o_count      (w_count[g]),
         .o_nonzero    (nonzero[g]),
         .o_expire     (expire[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_count <= '0;
      end else begin
         r_rd_count <= w_rd_mux;
      end
   end

   assign rd_count = r_rd_count;

endmodule

// File: tb/tb_dec_count_bank.sv
// Bench for dec_count_bank: a 6-channel/4-bit bank against a behavioural model plus
// directed literal checks, and a 2-channel/16-bit bank for the full-range sweep.
module tb_dec_count_bank;

   localparam int NA = 6;
   localparam int WA = 4;
   localparam int CA = 3;
   localparam int NB = 2;
   localparam int WB = 16;
   localparam int CB = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_reset, a_enable, a_tick, a_load_valid, a_load_auto;
   logic [CA-1:0] a_load_chan, a_rd_chan;
   logic [WA-1:0] a_load_value, a_rd_count;
   logic [NA-1:0] a_nonzero, a_expire;

   logic          b_reset, b_enable, b_tick, b_load_valid, b_load_auto;
   logic [CB-1:0] b_load_chan, b_rd_chan;
   logic [WB-1:0] b_load_value, b_rd_count;
   logic [NB-1:0] b_nonzero, b_expire;

   dec_count_bank #(.NCHAN(NA), .WIDTH(WA)) u_dut_a (
      .clk        (clk),
      .reset      (a_reset),
      .enable     (a_enable),
      .tick       (a_tick),
      .load_valid (a_load_valid),
      .load_chan  (a_load_chan),
      .load_value (a_load_value),
      .load_auto  (a_load_auto),
      .rd_chan    (a_rd_chan),
      .rd_count   (a_rd_count),
      .nonzero    (a_nonzero),
      .expire     (a_expire)
   );

   dec_count_bank #(.NCHAN(NB), .WIDTH(WB)) u_dut_b (
      .clk        (clk),
      .reset      (b_reset),
      .enable     (b_enable),
      .tick       (b_tick),
      .load_valid (b_load_valid),
      .load_chan  (b_load_chan),
      .load_value (b_load_value),
      .load_auto  (b_load_auto),
      .rd_chan    (b_rd_chan),
      .rd_count   (b_rd_count),
      .nonzero    (b_nonzero),
      .expire     (b_expire)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_a(input int ch, input int val, input bit au);
      a_load_valid = 1'b1;
      a_load_chan  = CA'(ch);
      a_load_value = WA'(val);
      a_load_auto  = au;
   endtask

   // Behavioural model of bank A: plain integer counters updated per the channel rules.
   int          m_count  [NA];
   int          m_reload [NA];
   bit          m_auto   [NA];
   bit [NA-1:0] m_exp;
   int          m_rd;
   bit          m_live = 1'b0;

   always @(posedge clk) begin
      bit [NA-1:0] nx;
      nx = '0;
      if (a_reset) begin
         for (int i = 0; i < NA; i++) begin
            m_count[i] = 0; m_reload[i] = 0; m_auto[i] = 1'b0;
         end
         m_rd   = 0;
         m_live = 1'b1;
      end else begin
         m_rd = (int'(a_rd_chan) < NA) ? m_count[a_rd_chan] : 0;
         for (int i = 0; i < NA; i++) begin
            if (!a_enable) begin
               m_count[i] = 0; m_reload[i] = 0; m_auto[i] = 1'b0;
            end else if (a_load_valid && int'(a_load_chan) == i) begin
               m_count[i]  = int'(a_load_value);
               m_reload[i] = int'(a_load_value);
               m_auto[i]   = a_load_auto;
            end else if (a_tick && m_count[i] > 0) begin
               if (m_count[i] == 1) begin
                  nx[i]      = 1'b1;
                  m_count[i] = m_auto[i] ? m_reload[i] : 0;
               end else begin
                  m_count[i] = m_count[i] - 1;
               end
            end
         end
      end
      m_exp = nx;
   end

   always @(negedge clk) begin
      bit [NA-1:0] nz;
      if (m_live) begin
         for (int i = 0; i < NA; i++) nz[i] = (m_count[i] != 0);
         chk("model_nonzero", 32'(a_nonzero), 32'(nz));
         chk("model_expire", 32'(a_expire), 32'(m_exp));
         chk("model_rd_count", 32'(a_rd_count), m_rd);
      end
   end

   int pulses;
   int first_at;

   initial begin
      a_reset = 1'b1; a_enable = 1'b1; a_tick = 1'b0; a_load_valid = 1'b0;
      a_load_chan = '0; a_load_value = '0; a_load_auto = 1'b0; a_rd_chan = '0;
      b_reset = 1'b1; b_enable = 1'b1; b_tick = 1'b0; b_load_valid = 1'b0;
      b_load_chan = '0; b_load_value = '0; b_load_auto = 1'b0; b_rd_chan = '0;
      step(); step();
      chk("reset_nonzero", 32'(a_nonzero), 0);
      chk("reset_expire", 32'(a_expire), 0);
      chk("reset_rd_count", 32'(a_rd_count), 0);
      a_reset = 1'b0;

      // One-shot ch3=5: five ticks to expiry, then quiet.
      load_a(3, 5, 1'b0); step(); a_load_valid = 1'b0;
      chk("load_nonzero3", 32'(a_nonzero[3]), 1);
      a_tick = 1'b1; a_rd_chan = 3'd3;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("oneshot_expire3", 32'(a_expire[3]), (k == 5) ? 1 : 0);
         chk("oneshot_rd3", 32'(a_rd_count), (k <= 5) ? 6 - k : 0);
      end
      a_tick = 1'b0;

      // Auto-reload ch0=3: readback 3,2,1,3,2,1 and an expire every third tick.
      load_a(0, 3, 1'b1); a_rd_chan = 3'd0; step(); a_load_valid = 1'b0;
      a_tick = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step();
         chk("auto_rd0", 32'(a_rd_count), 3 - ((j - 1) % 3));
         chk("auto_expire0", 32'(a_expire[0]), (j % 3 == 0) ? 1 : 0);
      end
      a_tick = 1'b0;
      load_a(0, 0, 1'b0); step(); a_load_valid = 1'b0;

      // Load colliding with a terminal decrement wins, with no expire.
      load_a(2, 2, 1'b0); step(); a_load_valid = 1'b0;
      a_tick = 1'b1; step();
      load_a(2, 7, 1'b0); step();
      chk("collide_expire2", 32'(a_expire[2]), 0);
      a_load_valid = 1'b0; a_tick = 1'b0; a_rd_chan = 3'd2; step(); step();
      chk("collide_count2", 32'(a_rd_count), 7);
      load_a(2, 1, 1'b0); step();
      load_a(5, 4, 1'b0); a_tick = 1'b1; step();
      chk("other_load_expire2", 32'(a_expire[2]), 1);
      chk("other_load_nonzero2", 32'(a_nonzero[2]), 0);
      chk("other_load_nonzero5", 32'(a_nonzero[5]), 1);
      a_load_valid = 1'b0; a_tick = 1'b0;

      // Zero load stays idle under ticks.
      load_a(1, 0, 1'b0); step(); a_load_valid = 1'b0;
      a_tick = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("idle_nonzero1", 32'(a_nonzero[1]), 0);
         chk("idle_expire1", 32'(a_expire[1]), 0);
      end
      a_tick = 1'b0;

      // Enable drop clears the whole bank; ticks afterwards do nothing.
      load_a(4, 9, 1'b1); step(); a_load_valid = 1'b0;
      a_tick = 1'b1; step(); step();
      a_enable = 1'b0; step();
      chk("en_low_nonzero", 32'(a_nonzero), 0);
      chk("en_low_expire", 32'(a_expire), 0);
      a_enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("after_en_nonzero", 32'(a_nonzero), 0);
         chk("after_en_expire", 32'(a_expire), 0);
      end
      load_a(7, 9, 1'b1); a_rd_chan = 3'd7; step();
      chk("oor_load_nonzero", 32'(a_nonzero), 0);
      a_load_valid = 1'b0; step();
      chk("oor_rd_count", 32'(a_rd_count), 0);

      // Randomised traffic, checked every cycle by the model.
      for (int k = 0; k < 3000; k++) begin
         a_load_valid = ($urandom_range(0, 2) == 0);
         a_load_chan  = CA'($urandom_range(0, 7));
         a_load_value = WA'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15));
         a_load_auto  = $urandom_range(0, 1) == 1;
         a_tick       = ($urandom_range(0, 3) != 0);
         a_enable     = ($urandom_range(0, 63) != 0);
         a_reset      = ($urandom_range(0, 255) == 0);
         a_rd_chan    = CA'($urandom_range(0, 7));
         step();
      end
      a_reset = 1'b0; a_enable = 1'b1; a_tick = 1'b0; a_load_valid = 1'b0;

      // Full-range sweep on the 16-bit bank.
      b_reset = 1'b0;
      b_load_valid = 1'b1; b_load_chan = 1'b1; b_load_value = 16'hFFFF; b_load_auto = 1'b0;
      b_rd_chan = 1'b1;
      step(); b_load_valid = 1'b0; b_tick = 1'b1;
      pulses = 0; first_at = 0;
      for (int k = 1; k <= 65537; k++) begin
         step();
         if (k == 1) chk("b_rd_first", 32'(b_rd_count), 32'hFFFF);
         if (b_expire[1]) begin
            pulses++;
            if (first_at == 0) first_at = k;
         end
      end
      chk("b_expire_pulses", pulses, 1);
      chk("b_expire_tick", first_at, 65535);
      chk("b_idle_nonzero", 32'(b_nonzero), 0);

      b_tick = 1'b0;
      b_load_valid = 1'b1; b_load_value = 16'hFFFF;
      step(); b_load_valid = 1'b0; b_tick = 1'b1;
      for (int k = 1; k <= 99; k++) step();
      chk("b_before_reset_nonzero", 32'(b_nonzero), 2);
      b_reset = 1'b1; step();
      chk("b_reset_nonzero", 32'(b_nonzero), 0);
      chk("b_reset_rd_count", 32'(b_rd_count), 0);
      chk("b_reset_expire", 32'(b_expire), 0);
      b_reset = 1'b0; b_tick = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
